// File: rtl/mac_pkg.sv
// Shared types and default widths for the pair-MAC dot-product sequencer.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } mac_state_e;

  localparam int DEF_DW    = 8;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_ACC_W = 32;
  localparam int PROD_W    = 2*DEF_DW + 1;
  localparam int MAX_LEN   = (1 << DEF_LEN_W) - 1;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Operand stream in, result stream out; the sequencer is the slave side.
interface mac_dot_if #(
    parameter int DW    = mac_pkg::DEF_DW,
    parameter int ACC_W = mac_pkg::DEF_ACC_W
);
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    a, b, c, d;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, a, b, c, d, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, a, b, c, d, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mac_pair_dp.sv
// Combinational a*b + c*d, unsigned, at full 2*DW+1 precision.
module mac_pair_dp #(
    parameter int DW = mac_pkg::DEF_DW,
    parameter int PW = 2*DW + 1
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [PW-1:0] p
);
    assign p = PW'(a) * PW'(b) + PW'(c) * PW'(d);
endmodule

// File: rtl/mac_dot_sequencer.sv
// Job FSM, beat counter, product register and wrapping accumulator with sticky carry.
module mac_dot_sequencer
    import mac_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int LEN_W = DEF_LEN_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    mac_dot_if.slave         io
);
    localparam int PW = 2*DW + 1;

    mac_state_e       state, nxt;
    logic [LEN_W-1:0] rem;
    logic [PW-1:0]    p_comb, p_reg;
    logic             p_vld;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             accept, last, start_ok;
    logic [ACC_W:0]   sum;

    mac_pair_dp #(.DW(DW), .PW(PW)) u_dp (
        .a(io.a), .b(io.b), .c(io.c), .d(io.d), .p(p_comb)
    );

    assign accept   = io.in_valid && (state == RUN);
    assign last     = accept && (rem == LEN_W'(1));
    assign start_ok = start && (state == IDLE);
    assign sum      = {1'b0, acc} + (ACC_W+1)'(p_reg);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (len != '0) ? RUN : DONE;
            RUN:     if (last) nxt = FLUSH;
            FLUSH:   nxt = DONE;
            DONE:    if (io.out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            p_reg <= '0;
            p_vld <= 1'b0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= nxt;
            p_vld <= accept;
            if (accept) p_reg <= p_comb;
            // start only lands in IDLE, where p_vld is already low
            if (start_ok) begin
                rem <= len;
                acc <= '0;
                ovf <= 1'b0;
            end else begin
                if (accept) rem <= rem - LEN_W'(1);
                if (p_vld) begin
                    acc <= sum[ACC_W-1:0];
                    ovf <= ovf | sum[ACC_W];
                end
            end
        end
    end

    assign busy         = (state != IDLE);
    assign io.in_ready  = (state == RUN);
    assign io.out_valid = (state == DONE);
    assign io.out_data  = acc;
    assign io.out_ovf   = ovf;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench: two sequencers (ACC_W=32 and ACC_W=18) share one stimulus stream.
module tb_mac_dot_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       in_valid, out_ready;
    logic [7:0] a, b, c, d;
    logic       busy0, busy1;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mac_dot_if #(.DW(8), .ACC_W(32)) if0 ();
    mac_dot_if #(.DW(8), .ACC_W(18)) if1 ();

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;
    assign if0.a = a; assign if0.b = b; assign if0.c = c; assign if0.d = d;
    assign if1.a = a; assign if1.b = b; assign if1.c = c; assign if1.d = d;

    mac_dot_sequencer #(.DW(8), .LEN_W(8), .ACC_W(32)) dut0 (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy0), .io(if0.slave)
    );
    mac_dot_sequencer #(.DW(8), .LEN_W(8), .ACC_W(18)) dut1 (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy1), .io(if1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] ia, ib, ic, id);
        in_valid = 1'b1;
        a = ia; b = ib; c = ic; d = id;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;

        // 1. reset / idle
        tick(); tick();
        chk("rst_busy",      32'(busy0), 32'd0);
        chk("rst_in_ready",  32'(if0.in_ready), 32'd0);
        chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
        chk("rst_out_data",  if0.out_data, 32'd0);
        chk("rst_out_ovf",   32'(if0.out_ovf), 32'd0);
        rst = 1'b0;
        tick();

        // 2. basic job, back-to-back beats
        start_job(8'd3);
        chk("basic_busy",     32'(busy0), 32'd1);
        chk("basic_in_ready", 32'(if0.in_ready), 32'd1);
        beat(2, 3, 3, 5);
        beat(3, 4, 2, 1);
        beat(5, 3, 1, 2);
        chk("basic_flush_no_valid", 32'(if0.out_valid), 32'd0);
        chk("basic_flush_in_ready", 32'(if0.in_ready), 32'd0);
        tick();
        chk("basic_valid", 32'(if0.out_valid), 32'd1);
        chk("basic_data",  if0.out_data, 32'd52);
        chk("basic_ovf",   32'(if0.out_ovf), 32'd0);
        chk("basic_data18", 32'(if1.out_data), 32'd52);
        handshake();
        chk("basic_idle", 32'(busy0), 32'd0);

        // 3. flow control: input gaps, stray starts, consumer back-pressure
        start_job(8'd3);
        beat(2, 3, 3, 5);
        start = 1'b1; len = 8'd0;
        tick(); tick();
        start = 1'b0;
        chk("gap_acc_hold", if0.out_data, 32'd21);
        chk("gap_still_run", 32'(if0.in_ready), 32'd1);
        beat(3, 4, 2, 1);
        tick(); tick();
        beat(5, 3, 1, 2);
        tick();
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; len = 8'd5;
            chk($sformatf("hold_valid_%0d", i), 32'(if0.out_valid), 32'd1);
            chk($sformatf("hold_data_%0d", i), if0.out_data, 32'd52);
            tick();
        end
        // start during the accepting handshake must not relaunch
        handshake();
        start = 1'b0;
        chk("fc_start_ignored", 32'(busy0), 32'd0);
        chk("fc_data_after",    if0.out_data, 32'd52);

        // 4. zero-length job
        start_job(8'd0);
        chk("zero_valid",    32'(if0.out_valid), 32'd1);
        chk("zero_data",     if0.out_data, 32'd0);
        chk("zero_ovf",      32'(if0.out_ovf), 32'd0);
        chk("zero_in_ready", 32'(if0.in_ready), 32'd0);
        handshake();

        // 5. overflow on the narrow accumulator
        start_job(8'd3);
        for (int i = 0; i < 3; i++) beat(255, 255, 255, 255);
        tick();
        chk("ovf_valid18", 32'(if1.out_valid), 32'd1);
        chk("ovf_data18",  32'(if1.out_data), 32'd128006);
        chk("ovf_flag18",  32'(if1.out_ovf), 32'd1);
        chk("ovf_data32",  if0.out_data, 32'd390150);
        chk("ovf_flag32",  32'(if0.out_ovf), 32'd0);
        handshake();
        start_job(8'd1);
        beat(1, 1, 1, 1);
        tick();
        chk("post_ovf_data", 32'(if1.out_data), 32'd2);
        chk("post_ovf_flag", 32'(if1.out_ovf), 32'd0);
        handshake();

        // 6. reset mid-job, then a fresh job
        start_job(8'd3);
        beat(4, 4, 4, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",  32'(busy0), 32'd0);
        chk("mid_rst_valid", 32'(if0.out_valid), 32'd0);
        chk("mid_rst_data",  if0.out_data, 32'd0);
        tick(); tick();
        chk("mid_rst_no_valid", 32'(if0.out_valid), 32'd0);
        start_job(8'd1);
        beat(7, 3, 2, 1);
        chk("fresh_flush", 32'(if0.out_valid), 32'd0);
        tick();
        chk("fresh_valid", 32'(if0.out_valid), 32'd1);
        chk("fresh_data",  if0.out_data, 32'd23);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
